// File: rtl/rib_rr_arbiter.sv
// Round-robin NUM_M x NUM_S request/ack interconnect; grant locked per transaction, error on decode miss/timeout.
// Latency: req in IDLE -> s_req_o next cycle -> m_ack_o the cycle after the slave ack; masters stall by holding m_req_i.
module rib_rr_arbiter #(
  parameter int NUM_M   = 4,
  parameter int NUM_S   = 6,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SEL_HI  = 31,
  parameter int SEL_LO  = 28,
  parameter int TIMEOUT = 255,
  parameter logic [NUM_M-1:0] HOLD_MASK = NUM_M'(4'b1101),
  parameter logic [DW-1:0]    MISS_DATA = DW'(32'h00000001),
  localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_M-1:0]    m_req_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [NUM_M*AW-1:0] m_addr_i,
  input  logic [NUM_M*DW-1:0] m_data_i,
  output logic [NUM_M*DW-1:0] m_data_o,
  output logic [NUM_M-1:0]    m_ack_o,
  output logic [NUM_M-1:0]    m_err_o,
  output logic [NUM_S-1:0]    s_req_o,
  output logic [NUM_S-1:0]    s_we_o,
  output logic [NUM_S*AW-1:0] s_addr_o,
  output logic [NUM_S*DW-1:0] s_data_o,
  input  logic [NUM_S*DW-1:0] s_data_i,
  input  logic [NUM_S-1:0]    s_ack_i,
  output logic                hold_flag_o,
  output logic [GW-1:0]       grant_o,
  output logic                busy_o
);

  localparam int SW = SEL_HI - SEL_LO + 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  typedef struct packed {
    logic [GW-1:0] grant;
    logic [SW-1:0] sidx;
    logic          hit;
  } xact_t;

  state_e        state_q, state_d;
  logic [GW-1:0] rr_q, rr_d;
  xact_t         xact_q, xact_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          req_any;
  logic [GW-1:0] pick;
  logic [SW-1:0] pick_sel;
  int            best;
  int            off;

  // Lowest rotational distance from rr_q wins.
  always_comb begin
    req_any  = 1'b0;
    pick     = '0;
    pick_sel = '0;
    best     = NUM_M;
    off      = 0;
    for (int j = 0; j < NUM_M; j++) begin
      if (m_req_i[j]) begin
        off = (j + NUM_M - int'(rr_q)) % NUM_M;
        if (off < best) begin
          best     = off;
          req_any  = 1'b1;
          pick     = GW'(j);
          pick_sel = m_addr_i[j*AW+SEL_LO +: SW];
        end
      end
    end
  end

  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [AW-1:0] g_addr_z;
  logic [DW-1:0] g_data;

  always_comb begin
    g_we   = 1'b0;
    g_addr = '0;
    g_data = '0;
    for (int j = 0; j < NUM_M; j++) begin
      if (xact_q.grant == GW'(j)) begin
        g_we   = m_we_i[j];
        g_addr = m_addr_i[j*AW +: AW];
        g_data = m_data_i[j*DW +: DW];
      end
    end
    g_addr_z                = g_addr;
    g_addr_z[SEL_HI:SEL_LO] = '0;
  end

  logic          s_ack_sel;
  logic [DW-1:0] s_rdata_sel;

  always_comb begin
    s_ack_sel   = 1'b0;
    s_rdata_sel = '0;
    s_req_o     = '0;
    s_we_o      = '0;
    s_addr_o    = '0;
    s_data_o    = '0;
    for (int j = 0; j < NUM_S; j++) begin
      if (xact_q.hit && xact_q.sidx == SW'(j)) begin
        s_ack_sel   = s_ack_i[j];
        s_rdata_sel = s_data_i[j*DW +: DW];
        if (state_q == BUSY) begin
          s_req_o[j]             = 1'b1;
          s_we_o[j]              = g_we;
          s_addr_o[j*AW +: AW]   = g_addr_z;
          s_data_o[j*DW +: DW]   = g_data;
        end
      end
    end
  end

  always_comb begin
    m_ack_o  = '0;
    m_err_o  = '0;
    m_data_o = '0;
    if (state_q == RESP) begin
      for (int j = 0; j < NUM_M; j++) begin
        if (xact_q.grant == GW'(j)) begin
          m_ack_o[j]           = 1'b1;
          m_err_o[j]           = err_q;
          m_data_o[j*DW +: DW] = rdata_q;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    xact_d  = xact_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          xact_d.grant = pick;
          xact_d.sidx  = pick_sel;
          xact_d.hit   = (int'(pick_sel) < NUM_S);
          cnt_d        = '0;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (!xact_q.hit) begin
          rdata_d = MISS_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (s_ack_sel) begin
          rdata_d = s_rdata_sel;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == 16'(TIMEOUT)) begin
          rdata_d = MISS_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        rr_d    = (xact_q.grant == GW'(NUM_M - 1)) ? '0 : xact_q.grant + GW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      xact_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      xact_q  <= xact_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign grant_o     = xact_q.grant;
  assign hold_flag_o = (|(m_req_i & HOLD_MASK)) | busy_o;

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Directed bench for rib_rr_arbiter: read, decode miss, grant lock, timeout, round-robin, async reset.
module tb_rib_rr_arbiter;

  localparam int NM = 4;
  localparam int NS = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NM-1:0]    m_req_i = '0;
  logic [NM-1:0]    m_we_i = '0;
  logic [NM*32-1:0] m_addr_i = '0;
  logic [NM*32-1:0] m_data_i = '0;
  logic [NM*32-1:0] m_data_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [NS-1:0]    s_req_o;
  logic [NS-1:0]    s_we_o;
  logic [NS*32-1:0] s_addr_o;
  logic [NS*32-1:0] s_data_o;
  logic [NS*32-1:0] s_data_i = '0;
  logic [NS-1:0]    s_ack_i = '0;
  logic             hold_flag_o;
  logic [1:0]       grant_o;
  logic             busy_o;

  int n_chk = 0;
  int n_err = 0;

  rib_rr_arbiter #(.NUM_M(NM), .NUM_S(NS), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_data_i(m_data_i),
    .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .hold_flag_o(hold_flag_o), .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc();
    cyc();
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ack", 64'(m_ack_o), 64'd0);
    chk("rst_sreq", 64'(s_req_o), 64'd0);
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_mdata", 64'(|m_data_o), 64'd0);
    chk("rst_hold", 64'(hold_flag_o), 64'd0);
    rst = 1'b1;
    cyc();

    // Single read m0 -> s1
    m_req_i[0] = 1'b1;
    m_addr_i[0 +: 32] = 32'h1000_0010;
    s_ack_i[1] = 1'b1;
    s_data_i[32 +: 32] = 32'hDEAD_BEEF;
    #1;
    chk("rd_hold_idle", 64'(hold_flag_o), 64'd1);
    chk("rd_busy_idle", 64'(busy_o), 64'd0);
    cyc();
    chk("rd_sreq", 64'(s_req_o), 64'b000010);
    chk("rd_saddr", 64'(s_addr_o[32 +: 32]), 64'h0000_0010);
    chk("rd_saddr0", 64'(s_addr_o[0 +: 32]), 64'd0);
    chk("rd_swe", 64'(s_we_o), 64'd0);
    chk("rd_grant", 64'(grant_o), 64'd0);
    chk("rd_noack", 64'(m_ack_o), 64'd0);
    cyc();
    chk("rd_ack", 64'(m_ack_o), 64'b0001);
    chk("rd_err", 64'(m_err_o), 64'd0);
    chk("rd_data", 64'(m_data_o[0 +: 32]), 64'hDEAD_BEEF);
    chk("rd_sreq_off", 64'(s_req_o), 64'd0);
    m_req_i = '0;
    s_ack_i = '0;
    cyc();
    chk("rd_idle", 64'(busy_o), 64'd0);
    chk("rd_ack_once", 64'(m_ack_o), 64'd0);

    // Decode miss: m1 -> slave 7
    m_req_i[1] = 1'b1;
    m_addr_i[32 +: 32] = 32'h7000_0000;
    #1;
    chk("miss_hold_idle", 64'(hold_flag_o), 64'd0);
    cyc();
    chk("miss_sreq", 64'(s_req_o), 64'd0);
    chk("miss_grant", 64'(grant_o), 64'd1);
    chk("miss_hold_busy", 64'(hold_flag_o), 64'd1);
    cyc();
    chk("miss_ack", 64'(m_ack_o), 64'b0010);
    chk("miss_err", 64'(m_err_o), 64'b0010);
    chk("miss_data", 64'(m_data_o[32 +: 32]), 64'h1);
    m_req_i = '0;
    cyc();

    // Lock: m2 -> s2 write, ack in 5th BUSY cycle; m3 arrives meanwhile
    m_req_i[2] = 1'b1;
    m_we_i[2] = 1'b1;
    m_addr_i[64 +: 32] = 32'h2000_0040;
    m_data_i[64 +: 32] = 32'hCAFE_0002;
    cyc();
    chk("lk_grant", 64'(grant_o), 64'd2);
    chk("lk_sreq", 64'(s_req_o), 64'b000100);
    chk("lk_swe", 64'(s_we_o), 64'b000100);
    chk("lk_sdata", 64'(s_data_o[64 +: 32]), 64'hCAFE_0002);
    chk("lk_saddr", 64'(s_addr_o[64 +: 32]), 64'h0000_0040);
    m_req_i[3] = 1'b1;
    m_addr_i[96 +: 32] = 32'h3000_0000;
    s_ack_i[0] = 1'b1;
    for (int i = 1; i < 5; i++) begin
      cyc();
      chk("lk_hold_grant", 64'(grant_o), 64'd2);
      chk("lk_no_ack", 64'(m_ack_o), 64'd0);
    end
    s_ack_i = '0;
    s_ack_i[2] = 1'b1;
    s_data_i[64 +: 32] = 32'h1234_5678;
    cyc();
    chk("lk_ack", 64'(m_ack_o), 64'b0100);
    chk("lk_err", 64'(m_err_o), 64'd0);
    chk("lk_data", 64'(m_data_o[64 +: 32]), 64'h1234_5678);
    m_req_i[2] = 1'b0;
    m_we_i = '0;
    s_ack_i = '0;
    cyc();
    cyc();

    // Timeout: m3 -> s3, never acked
    chk("to_grant", 64'(grant_o), 64'd3);
    chk("to_sreq0", 64'(s_req_o), 64'b001000);
    for (int i = 1; i < 5; i++) begin
      cyc();
      chk("to_sreq", 64'(s_req_o), 64'b001000);
      chk("to_no_ack", 64'(m_ack_o), 64'd0);
    end
    cyc();
    chk("to_ack", 64'(m_ack_o), 64'b1000);
    chk("to_err", 64'(m_err_o), 64'b1000);
    chk("to_data", 64'(m_data_o[96 +: 32]), 64'h1);
    chk("to_sreq_off", 64'(s_req_o), 64'd0);
    m_req_i = '0;
    cyc();

    // Round-robin: all masters to s0, s0 always acks
    for (int k = 0; k < NM; k++) m_addr_i[k*32 +: 32] = 32'h0000_0100 + 32'(k * 4);
    s_ack_i[0] = 1'b1;
    s_data_i[0 +: 32] = 32'hA5A5_0000;
    m_req_i = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      cyc();
      chk("rr_grant", 64'(grant_o), 64'(t % 4));
      chk("rr_saddr", 64'(s_addr_o[0 +: 32]), 64'(32'h0000_0100 + 32'((t % 4) * 4)));
      cyc();
      chk("rr_ack", 64'(m_ack_o), 64'(4'b0001 << (t % 4)));
      chk("rr_data", 64'(m_data_o[(t % 4)*32 +: 32]), 64'hA5A5_0000);
      cyc();
    end

    // Async reset mid-BUSY; rr pointer would otherwise favour m1
    s_ack_i = '0;
    m_req_i = 4'b0011;
    m_addr_i[0 +: 32] = 32'h0000_0008;
    m_addr_i[32 +: 32] = 32'h0000_0004;
    cyc();
    chk("ar_grant_pre", 64'(grant_o), 64'd1);
    chk("ar_busy_pre", 64'(busy_o), 64'd1);
    #2;
    rst = 1'b0;
    m_req_i = 4'b0010;
    #1;
    chk("ar_busy", 64'(busy_o), 64'd0);
    chk("ar_sreq", 64'(s_req_o), 64'd0);
    chk("ar_grant", 64'(grant_o), 64'd0);
    chk("ar_hold", 64'(hold_flag_o), 64'd0);
    chk("ar_ack", 64'(m_ack_o), 64'd0);
    cyc();
    rst = 1'b1;
    m_req_i = 4'b0011;
    s_ack_i[0] = 1'b1;
    s_data_i[0 +: 32] = 32'h0BAD_F00D;
    cyc();
    chk("ar_grant_post", 64'(grant_o), 64'd0);
    chk("ar_saddr_post", 64'(s_addr_o[0 +: 32]), 64'h0000_0008);
    cyc();
    chk("ar_ack_post", 64'(m_ack_o), 64'b0001);
    chk("ar_data_post", 64'(m_data_o[0 +: 32]), 64'h0BAD_F00D);
    m_req_i = '0;
    s_ack_i = '0;
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rib_rr_arbiter.md
Name: rib_rr_arbiter

Overview:
Parametrised successor to the fixed-priority RIB interconnect. Connects NUM_M masters to NUM_S slaves through a registered request/acknowledge transaction FSM. Uses round-robin arbitration with the grant locked for the whole transaction, waits on slave acknowledges, and completes with an error response on decode miss or timeout. Sits between the core/JTAG/DMA masters and the peripheral slaves at the 0x4000_0000 peripheral base.

Parameters:
NUM_M, 4, number of masters (2..8)
NUM_S, 6, number of slaves (1..16)
AW, 32, address width
DW, 32, data width
SEL_HI, 31, MSB of slave-select field in address
SEL_LO, 28, LSB of slave-select field (field width SW = SEL_HI-SEL_LO+1)
TIMEOUT, 255, max BUSY cycles waiting for s_ack_i before error completion (1..65535)
HOLD_MASK, 4'b1101, per-master bit; hold_flag_o asserts while any masked master requests
MISS_DATA, 32'h00000001, read data returned on error completion (NOP encoding)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous active-low reset
m_req_i  in  NUM_M  per-master request; held high until matching m_ack_o
m_we_i  in  NUM_M  per-master write flag
m_addr_i  in  NUM_M*AW  flattened master addresses, master k at [k*AW +: AW]
m_data_i  in  NUM_M*DW  flattened master write data
m_data_o  out  NUM_M*DW  flattened read data, valid with m_ack_o
m_ack_o  out  NUM_M  one-cycle completion pulse per master
m_err_o  out  NUM_M  one-cycle error flag, coincident with m_ack_o
s_req_o  out  NUM_S  per-slave access strobe
s_we_o  out  NUM_S  per-slave write flag
s_addr_o  out  NUM_S*AW  flattened slave address, select field forced to zero
s_data_o  out  NUM_S*DW  flattened slave write data
s_data_i  in  NUM_S*DW  flattened slave read data
s_ack_i  in  NUM_S  slave completion; read data valid in same cycle
hold_flag_o  out  1  pipeline hold request
grant_o  out  clog2(NUM_M)  current granted master index (debug)
busy_o  out  1  high in BUSY or RESP

Behaviour:
- Reset (rst=0, async): FSM=IDLE, rr_ptr=0, grant=0, timeout counter=0, captured data=0. All outputs 0, except m_data_o: every lane=0.
- States: IDLE, BUSY, RESP.
- IDLE: if any m_req_i is high, pick the first requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_M. Register grant, decode slave index = addr[SEL_HI:SEL_LO] of the granted master, load counter=0, go to BUSY. No requester: stay in IDLE.
- BUSY:
  - Index < NUM_S: drive s_req_o[idx]=1, s_we_o[idx]=m_we_i[grant], s_addr_o lane=granted addr with select field zeroed, s_data_o lane=m_data_i[grant]. All other slave lanes are 0.
  - s_ack_i[idx]=1: capture s_data_i lane, err=0, go to RESP.
  - Counter reaches TIMEOUT without ack: capture MISS_DATA, err=1, go to RESP.
  - Otherwise increment counter.
  - Index >= NUM_S (decode miss): no s_req_o asserted; capture MISS_DATA, err=1, go to RESP next edge.
- RESP:
  - m_ack_o[grant]=1, m_err_o[grant]=err, m_data_o[grant]=captured data for exactly one cycle; other lanes 0.
  - rr_ptr=(grant+1) mod NUM_M, go to IDLE.
- Latency: request seen in IDLE at cycle 0 with slave acking immediately gives s_req_o in cycle 1 and m_ack_o in cycle 2. Minimum 3 cycles between back-to-back grants.
- Grant is locked from IDLE exit to RESP exit. New or higher requests never preempt.
- Masters must hold addr/we/data stable while m_req_i is high. A master dropping m_req_i mid-transaction does not abort it; the ack is still pulsed.
- s_ack_i on a non-selected slave, or outside BUSY, is ignored.
- hold_flag_o = |(m_req_i & HOLD_MASK) | busy_o. Combinational from registered state and inputs.
- Reset asserted mid-transaction: immediate return to IDLE, no ack issued, outputs cleared.

Test Plan:
- Single read: m0 reads 0x1000_0010, s1 acks in 1st BUSY cycle with 0xDEADBEEF. s1 sees s_req_o[1]=1 with addr 0x0000_0010 at cycle 1. m_ack_o[0]=1 with data 0xDEADBEEF, err=0 at cycle 2.
- Round-robin: m0..m3 all request continuously to s0, which always acks. Grants are 0,1,2,3,0 in order; each master gets exactly one ack per 12 cycles.
- Lock: m2 granted, s2 delays ack 5 cycles while m3 raises req. grant_o stays 2 until m2's ack, then grants m3.
- Decode miss: m1 reads 0x7000_0000 (NUM_S=6). No s_req_o asserted; m_ack_o[1]=1, m_err_o[1]=1, data 0x00000001 two cycles after the request.
- Timeout: TIMEOUT=4, s3 never acks. s_req_o[3] is high for 5 cycles, then m_ack_o with err=1 and data=MISS_DATA.
- Reset mid-BUSY: rst driven low during BUSY. All outputs 0 asynchronously; after release, a fresh m0 request is granted first (rr_ptr=0).
